// File: rtl/i2s_clk_gen_pkg.sv
// Shared types and helpers for the I2S/TDM bit-clock and frame-sync generator.
// Holds the framing mode codes, slot-width limits, config struct and its clamp.
package i2s_clk_pkg;

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_LJ  = 2'd1;
    localparam logic [1:0] MODE_TDM = 2'd2;

    localparam int SLOT_MIN = 8;
    localparam int SLOT_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK_WAIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [7:0] div;
        logic [5:0] slot_bits;
        logic [1:0] mode;
    } cfg_t;

    // Divider 0 means 1, slot width is held to 8..32, and the reserved mode falls back to I2S.
    function automatic cfg_t cfg_clamp(input logic [7:0] div, input logic [5:0] bits,
                                       input logic [1:0] mode);
        cfg_t c;
        c.div = (div == 8'd0) ? 8'd1 : div;
        if (bits < 6'(SLOT_MIN))
            c.slot_bits = 6'(SLOT_MIN);
        else if (bits > 6'(SLOT_MAX))
            c.slot_bits = 6'(SLOT_MAX);
        else
            c.slot_bits = bits;
        c.mode = (mode == 2'd3) ? MODE_I2S : mode;
        return c;
    endfunction

endpackage

// File: rtl/i2s_clk_gen_if.sv
// Bundle between the clock generator (master) and the I2S TX/RX and config logic (slave).
// It carries the config handshake together with the generated clocks and the position counters.
interface i2s_clk_gen_if #(
    parameter int NUM_SLOTS = 2
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic          cfg_valid;
    logic          cfg_ready;
    logic [7:0]    cfg_bclk_div;
    logic [5:0]    cfg_slot_bits;
    logic [1:0]    cfg_mode;
    logic          running;
    logic          bclk;
    logic          lrclk;
    logic          bclk_fall_en;
    logic          bclk_rise_en;
    logic          frame_start;
    logic [SW-1:0] slot_idx;
    logic [4:0]    bit_idx;

    modport master (
        input  cfg_valid, cfg_bclk_div, cfg_slot_bits, cfg_mode,
        output cfg_ready, running, bclk, lrclk, bclk_fall_en, bclk_rise_en,
               frame_start, slot_idx, bit_idx
    );

    modport slave (
        output cfg_valid, cfg_bclk_div, cfg_slot_bits, cfg_mode,
        input  cfg_ready, running, bclk, lrclk, bclk_fall_en, bclk_rise_en,
               frame_start, slot_idx, bit_idx
    );
endinterface

// File: rtl/i2s_clk_gen_lock_filter.sv
// Synchronises the raw PLL lock and qualifies it with a run-length count.
// o_lock_ok is high on the LOCK_FILT-th consecutive synchronised-high cycle and after it.
module i2s_lock_filter #(
    parameter int LOCK_FILT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lock,
    output logic o_lock_sync,
    output logic o_lock_ok
);
    localparam int CW = $clog2(LOCK_FILT + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_lock};
            if (!r_sync[1])
                r_cnt <= '0;
            else if (r_cnt != CW'(LOCK_FILT - 1))
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_lock_sync = r_sync[1];
    assign o_lock_ok   = r_sync[1] && (r_cnt == CW'(LOCK_FILT - 1));
endmodule

// File: rtl/i2s_clk_gen.sv
// I2S/LJ/TDM bit-clock and frame-sync generator, gated on a filtered PLL lock.
// A config lands in a shadow register and becomes active at a frame boundary, or at once when idle.
module i2s_clk_gen
    import i2s_clk_pkg::*;
#(
    parameter int NUM_SLOTS     = 2,
    parameter int LOCK_FILT     = 1024,
    parameter int DEF_BCLK_DIV  = 4,
    parameter int DEF_SLOT_BITS = 32,
    parameter int DEF_MODE      = 0
) (
    input  logic          i_clkin1,
    input  logic          i_pll_rst,
    input  logic          i_pll_lock,
    i2s_clk_gen_if.master bus
);
    localparam int   SW      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam cfg_t DEF_CFG = cfg_clamp(8'(DEF_BCLK_DIV), 6'(DEF_SLOT_BITS), 2'(DEF_MODE));

    logic          w_lock_sync, w_lock_ok;
    state_t        r_state, w_state_nxt;
    cfg_t          r_act, r_shadow, w_cfg_nxt;
    logic          r_shadow_full;
    logic [7:0]    r_half;
    logic          r_bclk, r_lrclk, r_rise, r_fall, r_fstart;
    logic [SW-1:0] r_slot, w_slot_nxt;
    logic [4:0]    r_bit, w_bit_nxt;
    logic          w_stay, w_tick, w_fall, w_bit_last, w_last, w_wrap, w_apply, w_accept;
    logic [9:0]    w_fb, w_bc, w_bc1;
    logic          w_lr_nxt;

    i2s_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_lock (
        .i_clk       (i_clkin1),
        .i_rst       (i_pll_rst),
        .i_lock      (i_pll_lock),
        .o_lock_sync (w_lock_sync),
        .o_lock_ok   (w_lock_ok)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:      if (w_lock_sync) w_state_nxt = ST_LOCK_WAIT;
            ST_LOCK_WAIT: if (!w_lock_sync) w_state_nxt = ST_IDLE;
                          else if (w_lock_ok) w_state_nxt = ST_RUN;
            ST_RUN:       if (!w_lock_sync) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_stay     = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    assign w_tick     = (r_half == r_act.div - 8'd1);
    assign w_fall     = w_stay && w_tick && r_bclk;
    assign w_bit_last = ({1'b0, r_bit} == r_act.slot_bits - 6'd1);
    assign w_last     = w_bit_last && (r_slot == SW'(NUM_SLOTS - 1));
    assign w_wrap     = w_fall && w_last;
    assign w_accept   = bus.cfg_valid && !r_shadow_full;
    assign w_apply    = r_shadow_full && (w_wrap || (r_state != ST_RUN));
    assign w_cfg_nxt  = w_apply ? r_shadow : r_act;

    always_comb begin
        w_bit_nxt  = r_bit + 5'd1;
        w_slot_nxt = r_slot;
        if (w_last) begin
            w_bit_nxt  = '0;
            w_slot_nxt = '0;
        end else if (w_bit_last) begin
            w_bit_nxt  = '0;
            w_slot_nxt = r_slot + SW'(1);
        end
    end

    // Frame-sync level derives from the post-fall bit position under the config that governs it.
    assign w_fb  = 10'(NUM_SLOTS) * 10'(w_cfg_nxt.slot_bits);
    assign w_bc  = 10'(w_slot_nxt) * 10'(w_cfg_nxt.slot_bits) + 10'(w_bit_nxt);
    assign w_bc1 = (w_bc == w_fb - 10'd1) ? 10'd0 : w_bc + 10'd1;

    always_comb begin
        unique case (w_cfg_nxt.mode)
            MODE_LJ:  w_lr_nxt = (w_bc < (w_fb >> 1));
            MODE_TDM: w_lr_nxt = (w_bc == w_fb - 10'd1);
            default:  w_lr_nxt = (w_bc1 >= (w_fb >> 1));
        endcase
    end

    always_ff @(posedge i_clkin1) begin
        if (i_pll_rst) begin
            r_state       <= ST_IDLE;
            r_act         <= DEF_CFG;
            r_shadow      <= DEF_CFG;
            r_shadow_full <= 1'b0;
            r_half        <= '0;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_fstart      <= 1'b0;
            r_slot        <= '0;
            r_bit         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shadow      <= cfg_clamp(bus.cfg_bclk_div, bus.cfg_slot_bits, bus.cfg_mode);
                r_shadow_full <= 1'b1;
            end else if (w_apply) begin
                r_shadow_full <= 1'b0;
            end
            if (w_apply)
                r_act <= r_shadow;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_fstart <= 1'b0;
            if (w_stay) begin
                if (w_tick) begin
                    r_half <= '0;
                    r_bclk <= ~r_bclk;
                    r_rise <= ~r_bclk;
                    r_fall <= r_bclk;
                end else begin
                    r_half <= r_half + 8'd1;
                end
                if (w_fall) begin
                    r_slot   <= w_slot_nxt;
                    r_bit    <= w_bit_nxt;
                    r_lrclk  <= w_lr_nxt;
                    r_fstart <= w_last;
                end
            end else begin
                r_half  <= '0;
                r_bclk  <= 1'b0;
                r_lrclk <= 1'b0;
                // Entering RUN parks the counters on the last bit so the first fall opens a frame.
                if (w_state_nxt == ST_RUN) begin
                    r_slot <= SW'(NUM_SLOTS - 1);
                    r_bit  <= 5'(w_cfg_nxt.slot_bits - 6'd1);
                end else begin
                    r_slot <= '0;
                    r_bit  <= '0;
                end
            end
        end
    end

    assign bus.cfg_ready    = ~r_shadow_full;
    assign bus.running      = (r_state == ST_RUN);
    assign bus.bclk         = r_bclk;
    assign bus.lrclk        = r_lrclk;
    assign bus.bclk_fall_en = r_fall;
    assign bus.bclk_rise_en = r_rise;
    assign bus.frame_start  = r_fstart;
    assign bus.slot_idx     = r_slot;
    assign bus.bit_idx      = r_bit;
endmodule
